// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered one-hot decoder with handshake direct mode and dwell-timed scan mode (ONEHOT_SCAN_BLANK_EN adds a blank cycle between scan positions)
module onehot_scan_decoder #(
  parameter int SEL_W = 3,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    scan_start,
  input  logic                    stop,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    scan_wrap
);
  localparam int OUT_W = 1 << SEL_W;
`ifdef ONEHOT_SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, HOLD, SCAN, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
`endif
  state_t state, state_n;
  logic [OUT_W-1:0] out_n;
  logic [SEL_W-1:0] pos, pos_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_reg, dwell_n;
  logic wrap_n, scanning, scanning_n;
`ifdef ONEHOT_SCAN_BLANK_EN
  assign scanning = state == SCAN || state == BLANK;
  assign scanning_n = state_n == SCAN || state_n == BLANK;
`else
  assign scanning = state == SCAN;
  assign scanning_n = state_n == SCAN;
`endif
  assign sel_ready = !scanning && !scan_start && !stop;
  always_comb begin
    state_n = state;
    out_n = out;
    pos_n = pos;
    cnt_n = cnt;
    dwell_n = dwell_reg;
    wrap_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      out_n = '0;
    end else if (scan_start && !scanning) begin
      state_n = SCAN;
      pos_n = '0;
      cnt_n = '0;
      dwell_n = dwell;
      out_n = OUT_W'(1);
    end else if (sel_valid && sel_ready) begin
      state_n = HOLD;
      out_n = OUT_W'(1) << sel;
    end else if (state == SCAN) begin
      if (cnt == dwell_reg) begin
        cnt_n = '0;
        pos_n = pos + 1'b1;
`ifdef ONEHOT_SCAN_BLANK_EN
        state_n = BLANK;
        out_n = '0;
`else
        out_n = OUT_W'(1) << pos_n;
        wrap_n = &pos;
`endif
      end else begin
        cnt_n = cnt + 1'b1;
      end
`ifdef ONEHOT_SCAN_BLANK_EN
    end else if (state == BLANK) begin
      state_n = SCAN;
      out_n = OUT_W'(1) << pos;
      wrap_n = pos == '0;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      scan_wrap <= 1'b0;
      pos <= '0;
      cnt <= '0;
      dwell_reg <= '0;
    end else begin
      state <= state_n;
      out <= out_n;
      out_valid <= |out_n;
      busy <= scanning_n;
      scan_wrap <= wrap_n;
      pos <= pos_n;
      cnt <= cnt_n;
      dwell_reg <= dwell_n;
    end
  end
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed checks of reset, direct mode, scan timing, stop, priority and mid-scan reset
module tb_onehot_scan_decoder;
  logic clk = 1'b0, rst = 1'b1, sel_valid = 1'b0, scan_start = 1'b0, stop = 1'b0;
  logic sel_ready, out_valid, busy, scan_wrap;
  logic [2:0] sel = '0;
  logic [7:0] dwell = '0, out;
  int checks = 0, failures = 0;
  onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_ready(sel_ready), .sel(sel),
    .scan_start(scan_start), .stop(stop), .dwell(dwell), .out(out),
    .out_valid(out_valid), .busy(busy), .scan_wrap(scan_wrap)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", scan_wrap, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", sel_ready, 1);
    sel_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      chk("direct_out", out, 32'd1 << i);
      chk("direct_valid", out_valid, 1);
    end
    sel_valid = 1'b0;
    tick();
    chk("direct_hold", out, 32'h80);
    dwell = 8'd2;
    sel = 3'd5;
    sel_valid = 1'b1;
    scan_start = 1'b1;
    #1;
    chk("start_ready", sel_ready, 0);
    tick();
    scan_start = 1'b0;
    dwell = 8'd7;
    for (int c = 1; c <= 31; c++) begin
      if (c > 1) tick();
      chk("scan_out", out, 32'd1 << (((c - 1) / 3) % 8));
      chk("scan_wrap", scan_wrap, c == 25);
      chk("scan_busy", busy, 1);
      chk("scan_ready", sel_ready, 0);
      scan_start = c == 26;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_out", out, 0);
    chk("stop_valid", out_valid, 0);
    chk("stop_busy", busy, 0);
    tick();
    chk("after_stop_sel", out, 32'h20);
    sel = 3'd6;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    scan_start = 1'b1;
    dwell = 8'd0;
    tick();
    scan_start = 1'b0;
    sel_valid = 1'b0;
    chk("start_vs_sel_out", out, 32'h01);
    chk("start_vs_sel_busy", busy, 1);
    stop = 1'b1;
    tick();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    stop = 1'b0;
    chk("start_vs_stop_out", out, 0);
    chk("start_vs_stop_busy", busy, 0);
    tick();
    chk("idle_stays", out, 0);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    while (out != 8'h10 && checks < 1000) begin
      tick();
      checks++;
    end
    chk("pre_rst_out", out, 32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
`ifdef ONEHOT_SCAN_BLANK_EN
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      chk("blank_out", out, (k % 2 == 0) ? (32'd1 << ((k / 2) % 8)) : 32'd0);
      chk("blank_valid", out_valid, k % 2 == 0);
      chk("blank_wrap", scan_wrap, k == 16);
      chk("blank_busy", busy, 1);
    end
`else
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      chk("d0_out", out, 32'd1 << (k % 8));
      chk("d0_wrap", scan_wrap, k == 8);
      chk("d0_busy", busy, 1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
